rv32_muldiv: RTL and testbench



---
 rtl/rv32_muldiv.sv | 208 ++++++++++++++++++++
 tb/tb_rv32_muldiv.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_muldiv.sv
// rv32_muldiv: iterative RV32M multiply/divide unit sitting beside the ALU in execute.
// Optional define RV32_MULDIV_FAST_MUL_EN replaces iterative multiply with a single-cycle product.
module rv32_muldiv #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            start_in,
  input  logic            valid_in,
  input  logic [2:0]      op_in,
  input  logic [4:0]      rd_in,
  input  logic            rd_write_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  output logic            busy_out,
  output logic            valid_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic [XLEN-1:0] result_out
);

  localparam int K  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(K + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            rd_write_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] b_q;
  logic            neg_q;
  logic            bypass_q;
  logic [CW-1:0]   cnt_q;

  logic            sign_a_in;
  logic            sign_b_in;
  logic            neg_in;
  logic            div_zero_in;
  logic            div_ovf_in;
  logic [XLEN-1:0] mag_a_in;
  logic [XLEN-1:0] mag_b_in;
  logic [XLEN-1:0] special_in;

  // Accept-time decode: operand signs, magnitudes and the results that skip iteration.
  always_comb begin
    sign_a_in   = ((op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) ||
                   (op_in == OP_REM)) && rs1_value_in[XLEN-1];
    sign_b_in   = ((op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM)) &&
                  rs2_value_in[XLEN-1];
    mag_a_in    = sign_a_in ? -rs1_value_in : rs1_value_in;
    mag_b_in    = sign_b_in ? -rs2_value_in : rs2_value_in;
    neg_in      = (op_in[2:1] == 2'b11) ? sign_a_in : (sign_a_in ^ sign_b_in);
    div_zero_in = op_in[2] && (rs2_value_in == '0);
    div_ovf_in  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                  (rs1_value_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_value_in == '1);
    special_in  = '0;
    if (div_zero_in)
      special_in = op_in[1] ? rs1_value_in : '1;
    else if (div_ovf_in)
      special_in = op_in[1] ? '0 : rs1_value_in;
  end

  logic [XLEN-1:0] step_acc;
  logic [XLEN-1:0] step_lo;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   sum;

  // acc/lo hold remainder/quotient for divides and high/low product halves for multiplies.
  always_comb begin
    step_acc = acc_q;
    step_lo  = lo_q;
    trial    = '0;
    sum      = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        trial = {step_acc, step_lo[XLEN-1]} - {1'b0, b_q};
        if (!trial[XLEN]) begin
          step_acc = trial[XLEN-1:0];
          step_lo  = {step_lo[XLEN-2:0], 1'b1};
        end else begin
          step_acc = {step_acc[XLEN-2:0], step_lo[XLEN-1]};
          step_lo  = {step_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        sum      = {1'b0, step_acc} + (step_lo[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        step_lo  = {sum[0], step_lo[XLEN-1:1]};
        step_acc = sum[XLEN:1];
      end
    end
  end

  logic              fast_mul;
  logic              finish;
  logic [2*XLEN-1:0] full;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   final_result;

`ifdef RV32_MULDIV_FAST_MUL_EN
  assign fast_mul = !op_q[2];
`else
  assign fast_mul = 1'b0;
`endif

  assign finish = bypass_q || fast_mul || (cnt_q == CW'(K));

  // Sign correction and result selection, applied on the edge that enters DONE.
  always_comb begin
`ifdef RV32_MULDIV_FAST_MUL_EN
    full = {{XLEN{1'b0}}, lo_q} * {{XLEN{1'b0}}, b_q};
`else
    full = {acc_q, lo_q};
`endif
    if (neg_q)
      full = -full;
    quo = neg_q ? -lo_q : lo_q;
    rem = neg_q ? -acc_q : acc_q;
    final_result = rem;
    if (bypass_q)
      final_result = lo_q;
    else begin
      case (op_q)
        OP_MUL:                       final_result = full[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: final_result = full[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              final_result = quo;
        default:                      final_result = rem;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      valid_out    <= 1'b0;
      rd_out       <= '0;
      rd_write_out <= 1'b0;
      result_out   <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      rd_write_q   <= 1'b0;
      acc_q        <= '0;
      lo_q         <= '0;
      b_q          <= '0;
      neg_q        <= 1'b0;
      bypass_q     <= 1'b0;
      cnt_q        <= '0;
    end else if (flush_in) begin
      state        <= IDLE;
      valid_out    <= 1'b0;
      rd_write_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in && valid_in) begin
            op_q       <= op_in;
            rd_q       <= rd_in;
            rd_write_q <= rd_write_in;
            acc_q      <= '0;
            lo_q       <= (div_zero_in || div_ovf_in) ? special_in : mag_a_in;
            b_q        <= mag_b_in;
            neg_q      <= neg_in;
            bypass_q   <= div_zero_in || div_ovf_in;
            cnt_q      <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            result_out   <= final_result;
            valid_out    <= 1'b1;
            rd_out       <= rd_q;
            rd_write_out <= rd_write_q;
            state        <= DONE;
          end else begin
            acc_q <= step_acc;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (!stall_in) begin
            valid_out    <= 1'b0;
            rd_write_out <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_out = (state == BUSY);

endmodule

// File: tb/tb_rv32_muldiv.sv
// tb_rv32_muldiv: directed and randomized checks of rv32_muldiv against a 64-bit arithmetic model.
module tb_rv32_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in;
  logic        flush_in;
  logic        start_in;
  logic        valid_in;
  logic [2:0]  op_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic [31:0] rs1_value_in;
  logic [31:0] rs2_value_in;
  logic        busy_out;
  logic        valid_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] result_out;

  int checks = 0;
  int errors = 0;

  rv32_muldiv dut (
    .clk          (clk),
    .reset        (reset),
    .stall_in     (stall_in),
    .flush_in     (flush_in),
    .start_in     (start_in),
    .valid_in     (valid_in),
    .op_in        (op_in),
    .rd_in        (rd_in),
    .rd_write_in  (rd_write_in),
    .rs1_value_in (rs1_value_in),
    .rs2_value_in (rs2_value_in),
    .busy_out     (busy_out),
    .valid_out    (valid_out),
    .rd_out       (rd_out),
    .rd_write_out (rd_write_out),
    .result_out   (result_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural result computed with plain 64-bit arithmetic.
  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op >= 3'd4) begin
      if (b == 32'd0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 33;
    end
`ifdef RV32_MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Issue one op, wait for the result, optionally stall in DONE, then confirm it retires.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int holdCycles);
    int          edges;
    int          busyCycles;
    int          expLat;
    logic [31:0] expRes;
    logic [4:0]  rd;
    logic        rdw;
    expRes = refResult(op, a, b);
    expLat = refLatency(op, a, b);
    rd     = 5'($urandom);
    rdw    = 1'($urandom);
    op_in        = op;
    rs1_value_in = a;
    rs2_value_in = b;
    rd_in        = rd;
    rd_write_in  = rdw;
    start_in     = 1'b1;
    valid_in     = 1'b1;
    @(posedge clk); #1;
    start_in     = 1'b0;
    valid_in     = 1'b0;
    rs1_value_in = $urandom;
    rs2_value_in = $urandom;
    rd_in        = 5'($urandom);
    edges      = 0;
    busyCycles = 0;
    while (!valid_out && edges < 100) begin
      if (busy_out) busyCycles++;
      @(posedge clk); #1;
      edges++;
    end
    checkOutput($sformatf("latency op%0d", op), edges, expLat);
    checkOutput($sformatf("busy_cycles op%0d", op), busyCycles, expLat);
    checkOutput($sformatf("result op%0d a=%h b=%h", op, a, b), result_out, expRes);
    checkOutput("rd_out", rd_out, rd);
    checkOutput("rd_write_out", rd_write_out, rdw);
    checkOutput("done_busy", busy_out, 0);
    if (holdCycles > 0) begin
      stall_in = 1'b1;
      repeat (holdCycles) begin
        @(posedge clk); #1;
        checkOutput("stall_valid", valid_out, 1);
        checkOutput("stall_result", result_out, expRes);
      end
      stall_in = 1'b0;
    end
    @(posedge clk); #1;
    checkOutput("drop_valid", valid_out, 0);
    checkOutput("drop_rd_write", rd_write_out, 0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic sawValid;
    reset        = 1'b1;
    stall_in     = 1'b0;
    flush_in     = 1'b0;
    start_in     = 1'b0;
    valid_in     = 1'b0;
    op_in        = 3'd0;
    rd_in        = 5'd0;
    rd_write_in  = 1'b0;
    rs1_value_in = 32'd0;
    rs2_value_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy_out, 0);
    checkOutput("reset_valid", valid_out, 0);
    checkOutput("reset_rd_write", rd_write_out, 0);
    checkOutput("reset_rd", rd_out, 0);
    checkOutput("reset_result", result_out, 0);
    reset = 1'b0;

    applyStimulus(3'd5, 32'd100, 32'd7, 0);
    applyStimulus(3'd7, 32'd100, 32'd7, 0);
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2, 0);
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2, 0);
    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 0);
    applyStimulus(3'd5, 32'd5, 32'd0, 0);
    applyStimulus(3'd7, 32'd5, 32'd0, 0);
    applyStimulus(3'd4, 32'd5, 32'd0, 0);
    applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    applyStimulus(3'd0, 32'd6, 32'd7, 0);
    applyStimulus(3'd5, 32'd100, 32'd7, 4);

    // Flush at iteration 10 of a DIVU, then a new op the very next cycle.
    op_in = 3'd5; rs1_value_in = 32'd1000; rs2_value_in = 32'd7;
    rd_in = 5'd3; rd_write_in = 1'b1; start_in = 1'b1; valid_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0; valid_in = 1'b0;
    sawValid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (valid_out) sawValid = 1'b1;
    end
    flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    if (valid_out) sawValid = 1'b1;
    checkOutput("flush_saw_valid", sawValid, 0);
    checkOutput("flush_busy", busy_out, 0);
    checkOutput("flush_rd_write", rd_write_out, 0);
    applyStimulus(3'd5, 32'd9, 32'd3, 0);

    for (int i = 0; i < 40; i++)
      applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(),
                    ($urandom_range(0, 3) == 0) ? 2 : 0);

    // Reset in the middle of an iterating divide.
    op_in = 3'd5; rs1_value_in = 32'hDEADBEEF; rs2_value_in = 32'd13;
    rd_in = 5'd9; rd_write_in = 1'b1; start_in = 1'b1; valid_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0; valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset_busy", busy_out, 0);
    checkOutput("midreset_valid", valid_out, 0);
    checkOutput("midreset_rd_write", rd_write_out, 0);
    checkOutput("midreset_rd", rd_out, 0);
    checkOutput("midreset_result", result_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
